mux_rr_arbiter: RTL and testbench

- Round-robin controller that shares the 4:1 single-bit multiplexer between four requesters.
- Arbitrates the request lines and drives the 2-bit `select` of the mux datapath.
- Returns a one-hot grant to the winner and registers the muxed output bit `q`.
- Sits between requester logic and the mux, which is instantiated inside this block.

---
 rtl/mux_rr_arbiter.sv | 127 ++++++++++++
 tb/tb_mux_rr_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin owner of a 4:1 single-bit mux.
// Four level-sensitive requesters compete for the mux. The winner gets a
// one-hot registered grant. The mux select follows the winner, and the muxed
// bit is registered on q.
// Optional feature macro: MUX_ARB_TIMEOUT_EN. When it is defined, an owner
// that has held the mux for HOLD_MAX cycles while others wait is rotated out.
//
// state | meaning
// IDLE  | no owner, gnt = 0, select holds its last value
// OWN   | exactly one gnt bit high, select = encoded owner index
module mux_rr_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] d,
    output logic [3:0] gnt,
    output logic [1:0] select,
    output logic       busy,
    output logic       q
);

    localparam int            CW        = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t        state, state_nxt;
    logic [3:0]    gnt_nxt;
    logic [1:0]    select_nxt;
    logic [1:0]    last_owner, last_nxt;
    logic [CW-1:0] hold_cnt, hold_nxt;
    logic [3:0]    others;
    logic [1:0]    win;
    logic          timeout;
    logic          mux_out;
    logic          q_nxt;

    // First set bit of r searching upward from last+1 with wrap.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] idx;
        logic       found;
        rr_pick = last;
        found   = 1'b0;
        for (int k = 1; k < 5; k++) begin
            idx = last + 2'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // Requests other than the current owner; in IDLE this is simply req.
    assign others  = req & ~gnt;
    assign win     = rr_pick(others, last_owner);
    assign busy    = (state == OWN);
    assign mux_out = d[select];

`ifdef MUX_ARB_TIMEOUT_EN
    assign timeout = (hold_cnt == HOLD_LAST) && (|others);
`else
    assign timeout = 1'b0;
`endif

    // Next-state, grant, select and hold-counter logic.
    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt;
        select_nxt = select;
        last_nxt   = last_owner;
        hold_nxt   = hold_cnt;
        q_nxt      = busy ? mux_out : 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt  = OWN;
                    gnt_nxt    = 4'b0001 << win;
                    select_nxt = win;
                    last_nxt   = win;
                    hold_nxt   = '0;
                end
            end
            OWN: begin
                if (!(|(req & gnt)) || timeout) begin
                    if (|others) begin
                        gnt_nxt    = 4'b0001 << win;
                        select_nxt = win;
                        last_nxt   = win;
                        hold_nxt   = '0;
                    end else begin
                        state_nxt = IDLE;
                        gnt_nxt   = 4'b0000;
                        hold_nxt  = '0;
                    end
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_nxt = hold_cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 4'b0000;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt        <= 4'b0000;
            select     <= 2'd0;
            last_owner <= 2'd3;
            hold_cnt   <= '0;
            q          <= 1'b0;
        end else begin
            state      <= state_nxt;
            gnt        <= gnt_nxt;
            select     <= select_nxt;
            last_owner <= last_nxt;
            hold_cnt   <= hold_nxt;
            q          <= q_nxt;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter, instantiated with HOLD_MAX = 4.
// Define MUX_ARB_TIMEOUT_EN for both files to exercise the timeout build.
module tb_mux_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] gnt;
    logic [1:0] select;
    logic       busy;
    logic       q;

    int n_assert = 0;
    int n_fail   = 0;

    mux_rr_arbiter #(.HOLD_MAX(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .d      (d),
        .gnt    (gnt),
        .select (select),
        .busy   (busy),
        .q      (q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        chk("onehot", {3'b000, ($countones(gnt) <= 1)}, 4'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        d     = 4'b0000;
        #22;
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_sel", {2'b00, select}, 4'd0);
        chk("rst_busy", {3'b000, busy}, 4'd0);
        chk("rst_q", {3'b000, q}, 4'd0);
        rst_n = 1'b1;
        step();
        chk("idle_gnt", gnt, 4'b0000);

        // single requester 2
        req = 4'b0100;
        d   = 4'b0100;
        step();
        chk("single_gnt", gnt, 4'b0100);
        chk("single_sel", {2'b00, select}, 4'd2);
        chk("single_busy", {3'b000, busy}, 4'd1);
        chk("single_q0", {3'b000, q}, 4'd0);
        step();
        chk("single_q1", {3'b000, q}, 4'd1);
        d = 4'b0000;
        step();
        chk("single_qd0", {3'b000, q}, 4'd0);
        d = 4'b0100;
        step();
        chk("single_qd1", {3'b000, q}, 4'd1);

        // asynchronous reset mid-ownership
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", gnt, 4'b0000);
        chk("arst_sel", {2'b00, select}, 4'd0);
        chk("arst_busy", {3'b000, busy}, 4'd0);
        chk("arst_q", {3'b000, q}, 4'd0);
        req = 4'b1111;
        #1;
        rst_n = 1'b1;
        step();
        chk("arst_first_gnt", gnt, 4'b0001);
        chk("arst_first_sel", {2'b00, select}, 4'd0);

        // round-robin: each owner drops req for one cycle after 2 cycles
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_hold", gnt, 4'b0001 << i);
            req = 4'b1111 & ~(4'b0001 << i);
            step();
            chk("rr_next_gnt", gnt, 4'b0001 << ((i + 1) % 4));
            chk("rr_next_sel", {2'b00, select}, 4'((i + 1) % 4));
            chk("rr_busy", {3'b000, busy}, 4'd1);
            req = 4'b1111;
        end

        // release with nothing pending
        req = 4'b0010;
        d   = 4'b0010;
        step();
        chk("rel_gnt1", gnt, 4'b0010);
        step();
        chk("rel_q1", {3'b000, q}, 4'd1);
        req = 4'b0000;
        step();
        chk("rel_gnt0", gnt, 4'b0000);
        chk("rel_busy0", {3'b000, busy}, 4'd0);
        chk("rel_sel_hold", {2'b00, select}, 4'd1);
        chk("rel_q_last", {3'b000, q}, 4'd1);
        step();
        chk("rel_q0", {3'b000, q}, 4'd0);

        // requester 1 holds while requester 3 waits
        req = 4'b0010;
        step();
        chk("hold_gnt_start", gnt, 4'b0010);
        req = 4'b1010;
`ifdef MUX_ARB_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            step();
            chk("to_hold", gnt, 4'b0010);
        end
        step();
        chk("to_rotate", gnt, 4'b1000);
        chk("to_sel", {2'b00, select}, 4'd3);
        req = 4'b0010;
        step();
        chk("to_back1", gnt, 4'b0010);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("to_alone", gnt, 4'b0010);
        end
`else
        for (int i = 0; i < 20; i++) begin
            step();
            chk("nto_hold", gnt, 4'b0010);
        end
        req = 4'b1000;
        step();
        chk("nto_next", gnt, 4'b1000);
        chk("nto_sel", {2'b00, select}, 4'd3);
`endif
        req = 4'b0000;
        step();
        chk("end_idle", gnt, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
